// File: rtl/accum_pkg.sv
// accum_pkg: state encoding and default sizing for the sum accumulator
package accum_pkg;
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;
  localparam int DEF_IN_W = 5;
  localparam int DEF_N_TERMS = 4;
  localparam int DEF_ACC_W = 7;
endpackage

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums N_TERMS adder results per group and offers the total on a valid/ready port
module sum_accumulator
  import accum_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int N_TERMS = DEF_N_TERMS,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);
  state_t state, stateNext;
  logic [ACC_W-1:0] acc, accNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic ovf, ovfNext;
  logic [ACC_W:0] sum;
  logic take, lastBeat;
  assign sum = {1'b0, acc} + {{(ACC_W+1-IN_W){1'b0}}, in_data};
  assign take = in_valid && in_ready;
  assign lastBeat = cnt == CNT_W'(N_TERMS - 1);
  assign in_ready = state == ACCUM;
  assign out_valid = state == HOLD;
  // Partial totals stay hidden until the group is complete
  assign out_data = out_valid ? acc : '0;
  assign out_ovf = out_valid && ovf;
  always_comb begin
    stateNext = state;
    accNext = acc;
    cntNext = cnt;
    ovfNext = ovf;
    if (take) begin
      accNext = sum[ACC_W-1:0];
      ovfNext = ovf | sum[ACC_W];
      cntNext = lastBeat ? '0 : cnt + CNT_W'(1);
      stateNext = lastBeat ? HOLD : ACCUM;
    end else if (out_valid && out_ready) begin
      accNext = '0;
      ovfNext = 1'b0;
      stateNext = ACCUM;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      state <= stateNext;
      acc <= accNext;
      cnt <= cntNext;
      ovf <= ovfNext;
    end
  end
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed scenarios for the sum accumulator, default and narrowed accumulators
module tb_sum_accumulator;
  logic clk = 0, rst = 1;
  logic inValid = 0, outReady = 0, inReady, outValid, outOvf;
  logic [4:0] inData = 0;
  logic [6:0] outData;
  logic inValid6 = 0, outReady6 = 1, inReady6, outValid6, outOvf6;
  logic [4:0] inData6 = 0;
  logic [5:0] outData6;
  int checks = 0, errors = 0;

  sum_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_ovf(outOvf)
  );
  sum_accumulator #(.ACC_W(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(inValid6), .in_ready(inReady6), .in_data(inData6),
    .out_valid(outValid6), .out_ready(outReady6), .out_data(outData6), .out_ovf(outOvf6)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [4:0] d);
    inValid = 1;
    inData = d;
    tick();
    inValid = 0;
  endtask

  task automatic beat6(input logic [4:0] d);
    inValid6 = 1;
    inData6 = d;
    tick();
    inValid6 = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", inReady); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", outValid); end
    checks++; if (outData !== 7'd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", outData); end
    checks++; if (outOvf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b want 0", outOvf); end
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    outReady = 1;
    inValid = 1;
    inData = 5; tick();
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid got %b want 0", outValid); end
    checks++; if (outData !== 7'd0) begin errors++; $display("FAIL b2b_partial_hidden got %0d want 0", outData); end
    inData = 13; tick();
    inData = 31; tick();
    inData = 0; tick();
    inValid = 0;
    checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", outValid); end
    checks++; if (outData !== 7'd49) begin errors++; $display("FAIL b2b_data got %0d want 49", outData); end
    checks++; if (outOvf !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b want 0", outOvf); end
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL b2b_hold_ready got %b want 0", inReady); end
    tick();
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL b2b_ready_again got %b want 1", inReady); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got %b want 0", outValid); end
  endtask

  task automatic test_gaps_stall();
    logic [4:0] vals [4];
    vals = '{5'd2, 5'd3, 5'd7, 5'd6};
    outReady = 0;
    for (int i = 0; i < 4; i++) begin
      beat(vals[i]);
      if (i < 3) begin tick(); tick(); end
    end
    for (int i = 0; i < 5; i++) begin
      inValid = 1;
      inData = 9;
      checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL stall_valid cycle %0d got %b want 1", i, outValid); end
      checks++; if (outData !== 7'd18) begin errors++; $display("FAIL stall_data cycle %0d got %0d want 18", i, outData); end
      checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL stall_ready cycle %0d got %b want 0", i, inReady); end
      tick();
    end
    inValid = 0;
    outReady = 1;
    tick();
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL stall_release got %b want 0", outValid); end
    for (int i = 0; i < 4; i++) beat(5'd1);
    checks++; if (outData !== 7'd4) begin errors++; $display("FAIL stall_next_group got %0d want 4", outData); end
    tick();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) beat6(5'd31);
    checks++; if (outValid6 !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b want 1", outValid6); end
    checks++; if (outData6 !== 6'd60) begin errors++; $display("FAIL ovf_data got %0d want 60", outData6); end
    checks++; if (outOvf6 !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", outOvf6); end
    tick();
    for (int i = 0; i < 4; i++) beat6(5'd1);
    checks++; if (outData6 !== 6'd4) begin errors++; $display("FAIL ovf_clear_data got %0d want 4", outData6); end
    checks++; if (outOvf6 !== 1'b0) begin errors++; $display("FAIL ovf_clear_flag got %b want 0", outOvf6); end
    tick();
  endtask

  task automatic test_reset_mid();
    outReady = 0;
    for (int i = 0; i < 4; i++) beat(5'd5);
    checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL rst_hold_pre got %b want 1", outValid); end
    #3 rst = 1;
    #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid got %b want 0", outValid); end
    checks++; if (outData !== 7'd0) begin errors++; $display("FAIL rst_hold_data got %0d want 0", outData); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL rst_hold_ready got %b want 1", inReady); end
    rst = 0;
    outReady = 1;
    tick();
    beat(5'd10);
    beat(5'd12);
    #3 rst = 1;
    #1;
    checks++; if (outValid !== 1'b0 || outData !== 7'd0 || outOvf !== 1'b0 || inReady !== 1'b1) begin
      errors++; $display("FAIL rst_group got v=%b d=%0d o=%b r=%b want 0 0 0 1", outValid, outData, outOvf, inReady);
    end
    rst = 0;
    tick();
    for (int i = 1; i <= 4; i++) beat(5'(i));
    checks++; if (outData !== 7'd10) begin errors++; $display("FAIL rst_after_group got %0d want 10", outData); end
    checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL rst_after_valid got %b want 1", outValid); end
    tick();
  endtask

  task automatic test_max_throughput();
    outReady = 1;
    inValid = 1;
    inData = 1;
    for (int k = 1; k <= 20; k++) begin
      logic hold;
      tick();
      hold = (k % 5) == 4;
      checks++; if (outValid !== hold) begin errors++; $display("FAIL thru_valid cycle %0d got %b want %b", k, outValid, hold); end
      checks++; if (inReady !== !hold) begin errors++; $display("FAIL thru_ready cycle %0d got %b want %b", k, inReady, !hold); end
      checks++; if (outData !== (hold ? 7'd4 : 7'd0)) begin errors++; $display("FAIL thru_data cycle %0d got %0d want %0d", k, outData, hold ? 4 : 0); end
    end
    inValid = 0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps_stall();
    test_overflow();
    test_reset_mid();
    test_max_throughput();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
